// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract sequencer. One full-adder stage is reused for
//   WIDTH cycles, LSB first, with the carry held in a flip-flop between bits.
//   One operation is accepted per start/busy/done handshake. The result is
//   held on sum/cout until the next operation completes.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN
//     When defined, the block adds an ovf output that flags two's-complement
//     signed overflow. It is captured together with sum.
//
// Ports
//   Clk     rising-edge clock
//   Rst     asynchronous active-low reset
//   start   operation request, sampled when the sequencer is free
//   op_sub  0: a+b+cin, 1: a-b (cin ignored)
//   cin     carry-in for add
//   a, b    operands (WIDTH bits)
//   busy    high in RUN and DONE
//   done    one-cycle pulse, result valid
//   sum     result, held until the next completion
//   cout    final carry (for subtract: 1 = no borrow)
//   ovf     signed overflow (only with SERIAL_ADDER_OVF_EN)
module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  // The single adder cell: a full adder on the current LSBs and the carry FF.
  logic s, c;
  assign s = sa[0] ^ sb[0] ^ cy;
  assign c = (sa[0] & sb[0]) | (cy & (sa[0] ^ sb[0]));

  logic last;
  assign last = (cnt == CNT_W'(WIDTH - 1));

  // The edge that leaves DONE also acts as the IDLE acceptance edge.
  // This lets a continuously held start launch back-to-back operations
  // every WIDTH+1 cycles. A start seen during RUN is dropped.
  logic accept;
  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Subtract is done as a + ~b + 1.
        sa    <= a;
        sb    <= op_sub ? ~b : b;
        cy    <= op_sub | cin;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= {s, res[WIDTH-1:1]};
            cy  <= c;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              sum   <= {s, res[WIDTH-1:1]};
              cout  <= c;
`ifdef SERIAL_ADDER_OVF_EN
              // cy holds the carry into the MSB on this last bit.
              ovf   <= cy ^ c;
`endif
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         start, op_sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .op_sub(op_sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation and checks the handshake, the latency and the result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic top, input logic tci, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int n;
    @(negedge Clk);
    a = ta; b = tb_; op_sub = top; cin = tci; start = 1'b1;
    @(posedge Clk); #1;                       // E0
    chk({tag, " busy@E0"}, busy, 1);
    chk({tag, " done@E0"}, done, 0);
    @(negedge Clk);
    start = 1'b0; a = ~ta; b = ~tb_; op_sub = ~top;  // must not disturb the run
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      if (done) begin n = i; break; end
    end
    chk({tag, " latency"}, n, W);
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unused");
`endif
    @(posedge Clk); #1;
    chk({tag, " done drop"}, done, 0);
    chk({tag, " busy drop"}, busy, 0);
    chk({tag, " sum hold"}, sum, es);
  endtask

  int           ndone;
  int           exp_k [3] = '{8, 17, 26};
  logic [W-1:0] exp_s [3] = '{8'h01, 8'h1C, 8'h37};
  int           nd;

  initial begin
    Rst = 1'b0; start = 0; op_sub = 0; cin = 0; a = '0; b = '0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst ovf", ovf, 0);
`endif
    repeat (2) @(negedge Clk);
    Rst = 1'b1;

    run_op("add",    8'h3C, 8'h25, 0, 0, 8'h61, 0, 0);
    run_op("wrap",   8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    run_op("addcin", 8'h0F, 8'h10, 0, 1, 8'h20, 0, 0);
    run_op("sub1",   8'h10, 8'h20, 1, 1, 8'hF0, 0, 0);
    run_op("sub2",   8'h20, 8'h10, 1, 0, 8'h10, 1, 0);
    run_op("ovfadd", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    run_op("ovfsub", 8'h80, 8'h01, 1, 0, 8'h7F, 1, 1);

    // Hold start high with operands changing every cycle. Only the values
    // present at E0, E9 and E18 are launched.
    ndone = 0;
    op_sub = 0; cin = 0;
    for (int k = 0; k <= 27; k++) begin
      @(negedge Clk);
      start = 1'b1; a = W'(k + 1); b = W'(2 * k);
      @(posedge Clk); #1;
      if (k == 12) chk("hs hold", sum, 8'h01);
      if (done) begin
        nd = ndone;
        if (nd < 3) begin
          chk($sformatf("hs edge%0d", nd), k, exp_k[nd]);
          chk($sformatf("hs sum%0d", nd), sum, exp_s[nd]);
        end
        ndone++;
      end
    end
    chk("hs count", ndone, 3);
    chk("hs busy", busy, 1);
    @(negedge Clk);
    start = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    chk("hs idle", busy, 0);

    // Reset in the middle of a run.
    @(negedge Clk);
    a = 8'h3C; b = 8'h25; op_sub = 0; cin = 0; start = 1'b1;
    @(posedge Clk);                           // E0
    @(negedge Clk); start = 1'b0;
    repeat (3) @(posedge Clk);                // E3
    @(negedge Clk);
    Rst = 1'b0; #1;
    chk("mrst busy", busy, 0);
    chk("mrst done", done, 0);
    chk("mrst sum", sum, 0);
    chk("mrst cout", cout, 0);
    @(negedge Clk);
    Rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (done) ndone++;
    end
    chk("mrst no done", ndone, 0);
    chk("mrst sum hold", sum, 0);
    run_op("post", 8'h3C, 8'h25, 0, 0, 8'h61, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
